mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port to one-port memory arbiter with round-robin tie-break.
// The winning request is captured on grant so the downstream side never sees live port inputs.
module mem_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] p0_addr,
  input  logic [3:0]  p0_rmask,
  input  logic [3:0]  p0_wmask,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_resp,
  input  logic [31:0] p1_addr,
  input  logic [3:0]  p1_rmask,
  input  logic [3:0]  p1_wmask,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_rr_ptr;
  logic [31:0] r_addr;
  logic [3:0]  r_rmask;
  logic [3:0]  r_wmask;
  logic [31:0] r_wdata;

  logic w_req0;
  logic w_req1;
  logic w_grant;
  logic w_done;

  assign w_req0 = |(p0_rmask | p0_wmask);
  assign w_req1 = |(p1_rmask | p1_wmask);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1) begin
          w_state_next = r_rr_ptr ? GNT1 : GNT0;
        end else if (w_req0) begin
          w_state_next = GNT0;
        end else if (w_req1) begin
          w_state_next = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (mem_resp) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_grant = (r_state == GNT0) || (r_state == GNT1);
  assign w_done  = w_grant && mem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= RR_INIT;
      r_addr   <= '0;
      r_rmask  <= '0;
      r_wmask  <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_state_next == GNT0) begin
        r_addr  <= p0_addr;
        r_rmask <= p0_rmask;
        r_wmask <= p0_wmask;
        r_wdata <= p0_wdata;
      end else if (r_state == IDLE && w_state_next == GNT1) begin
        r_addr  <= p1_addr;
        r_rmask <= p1_rmask;
        r_wmask <= p1_wmask;
        r_wdata <= p1_wdata;
      end
      // Favour the port that was not just served, even after a single-port grant.
      if (w_done) begin
        r_rr_ptr <= (r_state == GNT0);
      end
    end
  end

  assign mem_addr  = w_grant ? r_addr  : '0;
  assign mem_rmask = w_grant ? r_rmask : '0;
  assign mem_wmask = w_grant ? r_wmask : '0;
  assign mem_wdata = w_grant ? r_wdata : '0;

  // A reset asserted in the completing cycle aborts the transfer, so resp is masked by rst.
  assign p0_resp  = (r_state == GNT0) && mem_resp && !rst;
  assign p1_resp  = (r_state == GNT1) && mem_resp && !rst;
  assign p0_rdata = p0_resp ? mem_rdata : '0;
  assign p1_rdata = p1_resp ? mem_rdata : '0;

endmodule
